// File: rtl/bcd_seq_converter_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// master drives operands and out_ready; slave is the converter.
interface bcd_seq_converter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_neg;
  logic                  busy;

  modport master (
    output in_valid,
    output in_bin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bcd,
    input  out_neg,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_bin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bcd,
    output out_neg,
    output busy
  );
endinterface

// File: rtl/bcd_seq_converter.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// Optional signed input handling is enabled by defining BCD_SIGNED_EN.
module bcd_seq_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_seq_converter_if.slave   bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  bin_q;
  logic [BW-1:0]     bcd_q;
  logic [BW-1:0]     obcd_q;
  logic              ovld_q;

  logic [BW-1:0]     adj;
  logic [BW+WIDTH-1:0] sh;
  logic [BW-1:0]     bcd_d;
  logic [WIDTH-1:0]  bin_d;
  logic [WIDTH-1:0]  mag_d;

  // Per-digit +3 on digits >= 5; no carry crosses a digit boundary.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign sh    = {adj, bin_q} << 1;
  assign bcd_d = sh[BW+WIDTH-1:WIDTH];
  assign bin_d = sh[WIDTH-1:0];

`ifdef BCD_SIGNED_EN
  logic sign_q;
  logic oneg_q;
  logic neg_d;

  assign neg_d = bus.in_bin[WIDTH-1];
  assign mag_d = neg_d ? (~bus.in_bin + WIDTH'(1))
                       : bus.in_bin;
  assign bus.out_neg = oneg_q;
`else
  assign mag_d = bus.in_bin;
  assign bus.out_neg = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      obcd_q  <= '0;
      ovld_q  <= 1'b0;
`ifdef BCD_SIGNED_EN
      sign_q  <= 1'b0;
      oneg_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            bin_q   <= mag_d;
            bcd_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            state_q <= SHIFT;
`ifdef BCD_SIGNED_EN
            sign_q  <= neg_d;
`endif
          end
        end
        SHIFT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            obcd_q  <= bcd_d;
            ovld_q  <= 1'b1;
            state_q <= DONE;
`ifdef BCD_SIGNED_EN
            oneg_q  <= sign_q;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            ovld_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.out_valid = ovld_q;
  assign bus.out_bcd   = obcd_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: driver pushes expectations,
// a monitor pops and compares on every output handshake.
module tb_bcd_seq_converter;

  logic clk;
  logic rst_n;

  bcd_seq_converter_if #(.WIDTH(8), .DIGITS(3)) bus ();

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [12:0] exp_q[$];

  int cyc = 0;
  int acc_edge = 0;
  int busy_cnt = 0;
  logic vprev = 1'b0;
  logic [12:0] hold_prev = '0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Edge bookkeeping: accept edge and busy cycles, sampled pre-update.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      busy_cnt <= 0;
    end else if (bus.in_valid && bus.in_ready) begin
      acc_edge <= cyc + 1;
      busy_cnt <= 0;
    end else if (bus.busy) begin
      busy_cnt <= busy_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      vprev = 1'b0;
    end else begin
      if (bus.out_valid && !vprev) begin
        check("latency", cyc - acc_edge, 8);
        check("busy_cycles", busy_cnt, 8);
      end
      if (bus.out_valid && vprev)
        check("hold", {bus.in_ready, bus.out_neg, bus.out_bcd},
              {1'b0, hold_prev});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          check("result", {bus.out_neg, bus.out_bcd}, exp_q.pop_front());
        end
      end
      vprev = bus.out_valid;
      hold_prev = {bus.out_neg, bus.out_bcd};
    end
  end

  task automatic send(input logic [7:0] b, input logic neg,
                      input logic [11:0] bcd, input bit push,
                      output int acc);
    int k;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_bin   = b;
    k = 0;
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("accept_timeout", 1, 0);
    if (push) exp_q.push_back({neg, bcd});
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("drain_timeout", 1, 0);
  endtask

  int a0, a1;
  int k;
  bit saw;

  initial begin
    rst_n = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_bin    = 8'hFF;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_bcd", bus.out_bcd, 12'h000);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_out_neg", bus.out_neg, 0);
`ifdef BCD_SIGNED_EN
    exp_q.push_back({1'b1, 12'h001});
`else
    exp_q.push_back({1'b0, 12'h255});
`endif
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_accept", bus.busy, 1);
    bus.in_valid = 1'b0;
    drain();

    send(8'h63, 1'b0, 12'h099, 1, a0);
    bus.in_valid = 1'b0;
    drain();
    send(8'h00, 1'b0, 12'h000, 1, a0);
    bus.in_valid = 1'b0;
    drain();

    // Backpressure with an ignored operand during the stall.
    bus.out_ready = 1'b0;
`ifdef BCD_SIGNED_EN
    send(8'hC8, 1'b1, 12'h056, 1, a0);
`else
    send(8'hC8, 1'b0, 12'h200, 1, a0);
`endif
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("bp_valid_seen", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = (i == 1 || i == 2);
      bus.in_bin   = 8'h11;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Abort in the middle of SHIFT.
    send(8'hAA, 1'b0, 12'h000, 0, a0);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) saw = 1;
    end
    check("abort_no_valid", saw, 0);

    send(8'h80, 1'b1, 12'h128, 0, a0);
`ifdef BCD_SIGNED_EN
    exp_q.push_back({1'b1, 12'h128});
`else
    exp_q.push_back({1'b0, 12'h128});
`endif
    bus.in_valid = 1'b0;
    drain();

    // Back-to-back with in_valid held high.
    send(8'h0A, 1'b0, 12'h010, 1, a0);
    send(8'h64, 1'b0, 12'h100, 1, a1);
    bus.in_valid = 1'b0;
    check("b2b_spacing", a1 - a0, 10);
    drain();

`ifdef BCD_SIGNED_EN
    send(8'hF6, 1'b1, 12'h010, 1, a0);
`else
    send(8'hF6, 1'b0, 12'h246, 1, a0);
`endif
    bus.in_valid = 1'b0;
    drain();
    send(8'h7F, 1'b0, 12'h127, 1, a0);
    bus.in_valid = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d want done", cyc);
    $fatal(1, "timeout");
  end

endmodule
